// File: rtl/pool_stream_if.sv
// Layer-1 memory read port plus the pooled-word output stream of pool_stream.
// The master side is the streamer; the slave side is the memory/consumer environment.
interface pool_stream_if;
    logic        crd;
    logic [11:0] caddr_rd;
    logic        csel;
    logic [12:0] cdata_rd;
    logic        o_valid;
    logic        o_ready;
    logic [12:0] o_data;
    logic [9:0]  o_index;
    logic        o_last;

    modport master (
        output crd, caddr_rd, csel, o_valid, o_data, o_index, o_last,
        input  cdata_rd, o_ready
    );

    modport slave (
        input  crd, caddr_rd, csel, o_valid, o_data, o_index, o_last,
        output cdata_rd, o_ready
    );
endinterface

// File: rtl/pool_stream.sv
// Streams N_WORDS layer-1 words from memory through a 2-entry FIFO to a ready/valid
// consumer, tracking the running maximum and sum of the accepted words.
module pool_stream #(
    parameter int N_WORDS   = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [12:0]   max_val,
    output logic [22:0]   sum,
    pool_stream_if.master bus
);
    localparam int DATA_W = 13;
    localparam int SUM_W  = 23;
    localparam int CNT_W  = $clog2(N_WORDS + 1);
    localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(N_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic              vld_p1;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_cnt;
    logic [2:0]        occ;
    logic              launch;
    logic              push;
    logic              pop;

    function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        return (b > a) ? b : a;
    endfunction

    function automatic logic [SUM_W-1:0] acc_u(input logic [SUM_W-1:0]  acc,
                                               input logic [DATA_W-1:0] x);
        return acc + SUM_W'(x);
    endfunction

    assign launch = (state == IDLE) && start;
    assign push   = vld_p1;
    assign pop    = bus.o_valid && bus.o_ready;

    assign bus.o_valid = (fifo_cnt != 2'd0);
    assign bus.o_data  = fifo_mem[rd_ptr];
    assign bus.o_index = 10'(out_cnt);
    assign bus.o_last  = bus.o_valid && (out_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (rd_cnt == END_CNT) state_nxt = DRAIN;
            DRAIN:   if (pop && bus.o_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A read may issue when the word it returns is guaranteed a FIFO slot; a pop
    // in the same cycle frees one, which keeps the stream at one word per cycle.
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        bus.csel     = 1'b0;
        bus.crd      = 1'b0;
        bus.caddr_rd = '0;
        occ          = {1'b0, fifo_cnt} + {2'b00, vld_p1};
        case (state)
            RUN: begin
                busy     = 1'b1;
                bus.csel = 1'b1;
                if ((rd_cnt < END_CNT) && ((occ < 3'd2) || ((occ == 3'd2) && pop))) begin
                    bus.crd      = 1'b1;
                    bus.caddr_rd = 12'(BASE_ADDR) + 12'(rd_cnt);
                end
            end
            DRAIN: begin
                busy     = 1'b1;
                bus.csel = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Read issue -> p1 (data returning) -> FIFO -> handshake and statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_cnt      <= '0;
            out_cnt     <= '0;
            vld_p1      <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            max_val     <= '0;
            sum         <= '0;
        end else if (launch) begin
            rd_cnt   <= '0;
            out_cnt  <= '0;
            vld_p1   <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
            max_val  <= '0;
            sum      <= '0;
        end else begin
            vld_p1 <= bus.crd;
            if (bus.crd) rd_cnt <= rd_cnt + CNT_W'(1);
            if (push) begin
                fifo_mem[wr_ptr] <= bus.cdata_rd;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                out_cnt <= out_cnt + CNT_W'(1);
                max_val <= max_u(max_val, bus.o_data);
                sum     <= acc_u(sum, bus.o_data);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_pool_stream.sv
// Randomized bench for pool_stream: a 1-cycle memory model feeds the block and a
// word-order/statistics reference model checks the stream it produces.
module tb_pool_stream;
    localparam int N    = 1024;
    localparam int BASE = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [12:0] max_val;
    logic [22:0] sum;

    pool_stream_if bus();

    pool_stream #(.N_WORDS(N), .BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .max_val (max_val),
        .sum     (sum),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [12:0] mem [0:4095];
    logic [12:0] exp_words [0:N-1];

    always @(posedge clk) if (bus.crd) bus.cdata_rd <= mem[bus.caddr_rd];

    int ready_mode;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.o_ready = 1'b0;
            1:       bus.o_ready = 1'b1;
            default: bus.o_ready = 1'($urandom_range(0, 1));
        endcase
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    int hs_cnt, rd_issued, done_cnt, crd_cnt, cyc, first_hs, last_hs;
    logic        held_v;
    logic [12:0] held_d;
    logic [9:0]  held_i;

    always @(negedge clk) begin
        if (reset) begin
            if (bus.crd) begin
                chk("caddr", 32'(bus.caddr_rd), 32'(BASE + rd_issued));
                chk("crd_room", 32'((rd_issued - hs_cnt - ((bus.o_valid && bus.o_ready) ? 1 : 0)) < 2), 1);
                rd_issued++;
                crd_cnt++;
            end
            if (held_v) begin
                chk("hold_valid", 32'(bus.o_valid), 1);
                chk("hold_data", 32'(bus.o_data), 32'(held_d));
                chk("hold_index", 32'(bus.o_index), 32'(held_i));
            end
            if (bus.o_valid && bus.o_ready) begin
                if (hs_cnt < N) begin
                    chk("data", 32'(bus.o_data), 32'(exp_words[hs_cnt]));
                    chk("index", 32'(bus.o_index), 32'(hs_cnt));
                    chk("last", 32'(bus.o_last), 32'(hs_cnt == N - 1));
                end else begin
                    chk("extra_word", 32'(hs_cnt), 32'(N - 1));
                end
                if (hs_cnt == 0) first_hs = cyc;
                last_hs = cyc;
                hs_cnt++;
            end
            held_v = bus.o_valid && !bus.o_ready;
            held_d = bus.o_data;
            held_i = bus.o_index;
            if (done) done_cnt++;
            cyc++;
        end
    end

    task automatic fill(input int mode);
        for (int i = 0; i < 4096; i++) begin
            case (mode)
                0:       mem[i] = 13'(i % 8192);
                1:       mem[i] = (i == BASE + 500) ? 13'd8191 : 13'd16;
                default: mem[i] = 13'($urandom_range(0, 8191));
            endcase
        end
    endtask

    task automatic start_run();
        for (int i = 0; i < N; i++) exp_words[i] = mem[BASE + i];
        hs_cnt = 0; rd_issued = 0; done_cnt = 0; crd_cnt = 0;
        held_v = 1'b0; first_hs = -1; last_hs = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        int k;
        int mx;
        int sm;
        k = 0;
        while (done_cnt == 0 && k < 20000) begin
            @(posedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != 0), 1);
        repeat (4) @(posedge clk);
        #1;
        mx = 0; sm = 0;
        for (int i = 0; i < N; i++) begin
            if (int'(exp_words[i]) > mx) mx = int'(exp_words[i]);
            sm += int'(exp_words[i]);
        end
        chk({tag, "_words"}, 32'(hs_cnt), 32'(N));
        chk({tag, "_reads"}, 32'(rd_issued), 32'(N));
        chk({tag, "_done_once"}, 32'(done_cnt), 1);
        chk({tag, "_max"}, 32'(max_val), 32'(mx));
        chk({tag, "_sum"}, 32'(sum), 32'(sm));
        chk({tag, "_idle_busy"}, 32'(busy), 0);
        chk({tag, "_idle_csel"}, 32'(bus.csel), 0);
    endtask

    task automatic wait_words(input int n);
        int k;
        k = 0;
        while (hs_cnt < n && k < 20000) begin
            @(posedge clk);
            k++;
        end
        chk("wait_words", 32'(hs_cnt >= n), 1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; ready_mode = 0; cyc = 0;
        hs_cnt = 0; rd_issued = 0; done_cnt = 0; crd_cnt = 0; held_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_crd", 32'(bus.crd), 0);
        chk("rst_csel", 32'(bus.csel), 0);
        chk("rst_valid", 32'(bus.o_valid), 0);
        chk("rst_last", 32'(bus.o_last), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_caddr", 32'(bus.caddr_rd), 0);
        chk("rst_data", 32'(bus.o_data), 0);
        chk("rst_index", 32'(bus.o_index), 0);
        chk("rst_max", 32'(max_val), 0);
        chk("rst_sum", 32'(sum), 0);
        reset = 1'b1;

        // Ramp data, consumer always ready: full rate stream.
        fill(0);
        ready_mode = 1;
        start_run();
        finish_run("ramp");
        chk("ramp_max_const", 32'(max_val), 1023);
        chk("ramp_sum_const", 32'(sum), 523776);
        chk("ramp_rate", 32'(last_hs - first_hs), 32'(N - 1));

        // Same data with a random consumer; a stray start mid-run must be ignored.
        ready_mode = 2;
        start_run();
        wait_words(100);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        finish_run("rand");

        // Stalled consumer: only two reads may go out and word 0 must be held.
        ready_mode = 0;
        start_run();
        repeat (20) @(posedge clk);
        #1;
        chk("stall_crd_cnt", 32'(crd_cnt), 2);
        chk("stall_valid", 32'(bus.o_valid), 1);
        chk("stall_data", 32'(bus.o_data), 32'(exp_words[0]));
        chk("stall_index", 32'(bus.o_index), 0);
        ready_mode = 1;
        finish_run("stall");

        // Single peak value.
        fill(1);
        ready_mode = 2;
        start_run();
        finish_run("peak");
        chk("peak_max_const", 32'(max_val), 8191);
        chk("peak_sum_const", 32'(sum), 24559);

        // Reset mid-run, then a fresh run on new data.
        fill(2);
        ready_mode = 2;
        start_run();
        wait_words(300);
        #2 reset = 1'b0;
        held_v = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_crd", 32'(bus.crd), 0);
        chk("abort_valid", 32'(bus.o_valid), 0);
        chk("abort_max", 32'(max_val), 0);
        chk("abort_sum", 32'(sum), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        crd_cnt = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_abort_busy", 32'(busy), 0);
        chk("post_abort_crd_cnt", 32'(crd_cnt), 0);
        chk("post_abort_valid", 32'(bus.o_valid), 0);
        fill(2);
        start_run();
        finish_run("fresh");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
